// File: rtl/toysram_scan_ctl_if.sv
// Host-side control bus of the scan controller: request, chain select, data and status.
interface toysram_scan_ctl_if #(
  parameter int unsigned LEN = 32,
  parameter int unsigned CSW = 1
);
  logic           start;
  logic           abort;
  logic [CSW-1:0] chain_sel;
  logic [LEN-1:0] wdata;
  logic [LEN-1:0] rdata;
  logic           busy;
  logic           done;
  logic           err;

  modport master (
    output start, abort, chain_sel, wdata,
    input  rdata, busy, done, err
  );

  modport slave (
    input  start, abort, chain_sel, wdata,
    output rdata, busy, done, err
  );
endinterface

// File: rtl/toysram_scan_ctl.sv
// Serial scan controller: shifts wdata into one of NCHAIN scan chains while
// capturing the chain's previous contents into rdata, using a divided scan clock.
module toysram_scan_ctl #(
  parameter int unsigned NCHAIN = 2,
  parameter int unsigned LEN    = 32,
  parameter int unsigned DIV    = 4,
  parameter int unsigned CSW    = (NCHAIN > 1) ? $clog2(NCHAIN) : 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  toysram_scan_ctl_if.slave bus,
  output logic [NCHAIN-1:0] scan_te,
  output logic [NCHAIN-1:0] scan_clk,
  output logic [NCHAIN-1:0] scan_in,
  input  logic [NCHAIN-1:0] scan_out
);
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, DONE} state_t;

  state_t            state, state_nx;
  logic [PW-1:0]     ph, ph_nx;
  logic [BW-1:0]     bit_cnt, bit_nx;
  logic [LEN-1:0]    sr, sr_nx;
  logic [CSW-1:0]    sel, sel_nx;
  logic [LEN-1:0]    rdata_nx;
  logic              busy_nx, done_nx, err_nx;
  logic [NCHAIN-1:0] te_nx, clk_nx, in_nx, sel_mask, cur_mask;
  logic              ph_last, sel_ok;

  assign ph_last  = (ph == PW'(DIV - 1));
  assign sel_ok   = (32'(bus.chain_sel) < NCHAIN);
  assign cur_mask = NCHAIN'(1) << sel;

  // Next-state, datapath and next-pin values; every pin is registered below.
  always_comb begin
    state_nx = state;
    ph_nx    = ph;
    bit_nx   = bit_cnt;
    sr_nx    = sr;
    sel_nx   = sel;
    rdata_nx = bus.rdata;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    busy_nx  = 1'b0;
    te_nx    = '0;
    clk_nx   = '0;
    in_nx    = '0;
    sel_mask = '0;

    if (state != IDLE && state != DONE) ph_nx = ph_last ? '0 : ph + PW'(1);

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (sel_ok) begin
            state_nx = SETUP;
            sr_nx    = bus.wdata;
            sel_nx   = bus.chain_sel;
            ph_nx    = '0;
            bit_nx   = '0;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      SETUP: if (ph_last) state_nx = LOW;
      LOW: begin
        // Capture the chain output before scan_clk rises on the same edge.
        if (ph_last) begin
          state_nx          = HIGH;
          sr_nx             = sr >> 1;
          sr_nx[LEN-1]      = |(scan_out & cur_mask);
        end
      end
      HIGH: begin
        if (ph_last) begin
          if (bit_cnt == BW'(LEN - 1)) begin
            state_nx = HOLD;
          end else begin
            state_nx = LOW;
            bit_nx   = bit_cnt + BW'(1);
          end
        end
      end
      HOLD: begin
        if (ph_last) begin
          state_nx = DONE;
          rdata_nx = sr;
          done_nx  = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    if (state != IDLE) begin
      if (bus.start) err_nx = 1'b1;
      if (bus.abort) begin
        state_nx = IDLE;
        ph_nx    = '0;
        bit_nx   = '0;
        rdata_nx = bus.rdata;
        done_nx  = 1'b0;
      end
    end

    sel_mask = NCHAIN'(1) << sel_nx;
    busy_nx  = (state_nx != IDLE);
    if (state_nx inside {SETUP, LOW, HIGH, HOLD}) te_nx = sel_mask;
    if (state_nx == HIGH) clk_nx = sel_mask;
    // scan_in is reloaded only on entry to LOW and held through the following HIGH.
    if (state_nx == LOW && state != LOW) in_nx = sr[0] ? sel_mask : '0;
    else if (state_nx inside {LOW, HIGH}) in_nx = scan_in;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      ph        <= '0;
      bit_cnt   <= '0;
      sr        <= '0;
      sel       <= '0;
      bus.rdata <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.err   <= 1'b0;
      scan_te   <= '0;
      scan_clk  <= '0;
      scan_in   <= '0;
    end else begin
      state     <= state_nx;
      ph        <= ph_nx;
      bit_cnt   <= bit_nx;
      sr        <= sr_nx;
      sel       <= sel_nx;
      bus.rdata <= rdata_nx;
      bus.busy  <= busy_nx;
      bus.done  <= done_nx;
      bus.err   <= err_nx;
      scan_te   <= te_nx;
      scan_clk  <= clk_nx;
      scan_in   <= in_nx;
    end
  end
endmodule

// File: tb/tb_toysram_scan_ctl.sv
// Scoreboard bench for toysram_scan_ctl: behavioural scan chains, expected
// completions/errors queued at issue time and checked by an independent monitor.
module tb_toysram_scan_ctl;
  localparam int unsigned NCHAIN = 2;
  localparam int unsigned LEN    = 8;
  localparam int unsigned DIV    = 2;
  localparam int unsigned CSW    = 2;
  localparam int          LAT    = 1 + DIV * (2 * LEN + 2);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NCHAIN-1:0] scan_te, scan_clk, scan_in, scan_out;

  toysram_scan_ctl_if #(.LEN(LEN), .CSW(CSW)) bus ();

  toysram_scan_ctl #(.NCHAIN(NCHAIN), .LEN(LEN), .DIV(DIV), .CSW(CSW)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus),
    .scan_te  (scan_te),
    .scan_clk (scan_clk),
    .scan_in  (scan_in),
    .scan_out (scan_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             cyc;
    logic [LEN-1:0] rdata;
    logic [LEN-1:0] chain;
    int             sel;
  } done_exp_t;

  done_exp_t         done_q[$];
  int                err_q[$];
  done_exp_t         e;
  int                compared   = 0;
  int                mismatched = 0;
  int                ncnt       = 0;
  int                op_start   = 0;
  int                last_rise  = -1;
  int                rises[NCHAIN];
  bit                op_active  = 1'b0;
  bit                checking   = 1'b0;
  logic [LEN-1:0]    chain[NCHAIN];
  logic [LEN-1:0]    rdata_model = '0;
  logic [NCHAIN-1:0] allowed   = '0;
  logic [NCHAIN-1:0] prev_clk  = '0;

  for (genvar g = 0; g < NCHAIN; g++) begin : g_out
    assign scan_out[g] = chain[g][0];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: chain model, pin rules, and scoreboard pops on done/err.
  always @(negedge clk) begin
    ncnt++;
    if (checking) begin
      for (int i = 0; i < NCHAIN; i++) begin
        if (scan_clk[i] === 1'b1 && prev_clk[i] !== 1'b1) begin
          if (scan_te[i] === 1'b1) chain[i] = {scan_in[i], chain[i][LEN-1:1]};
          rises[i]++;
          if (last_rise >= 0) check("scan_clk period", ncnt - last_rise, 2 * DIV);
          last_rise = ncnt;
        end
      end
      prev_clk = scan_clk;
      check("pins outside selected chain", (scan_te | scan_clk | scan_in) & ~allowed, 0);
      if (bus.done === 1'b1) begin
        if (done_q.size() == 0) begin
          check("unexpected done", done_q.size(), 1);
        end else begin
          e = done_q.pop_front();
          check("done cycle", ncnt, e.cyc);
          check("rdata", bus.rdata, e.rdata);
          check("chain contents", chain[e.sel], e.chain);
          check("scan_clk rises", rises[e.sel], LEN);
          rdata_model = e.rdata;
        end
      end
      if (bus.err === 1'b1) begin
        if (err_q.size() == 0) check("unexpected err", err_q.size(), 1);
        else check("err cycle", ncnt, err_q.pop_front());
      end
      check("rdata stable", bus.rdata, rdata_model);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input int sel, input logic [LEN-1:0] wd);
    bit accepted;
    accepted = 1'b0;
    bus.start     = 1'b1;
    bus.chain_sel = CSW'(sel);
    bus.wdata     = wd;
    if (op_active || sel >= NCHAIN) begin
      err_q.push_back(ncnt + 1);
    end else begin
      done_q.push_back('{cyc: ncnt + LAT, rdata: chain[sel], chain: wd, sel: sel});
      op_active = 1'b1;
      op_start  = ncnt;
      allowed   = NCHAIN'(1) << sel;
      rises     = '{default: 0};
      last_rise = -1;
      accepted  = 1'b1;
    end
    tick();
    bus.start = 1'b0;
    if (accepted) check("busy after accept", bus.busy, 1);
    else if (!op_active) check("busy after rejected start", bus.busy, 0);
  endtask

  task automatic finish_op();
    while (ncnt < op_start + LAT) tick();
    check("busy in done cycle", bus.busy, 1);
    tick();
    check("busy after done", bus.busy, 0);
    check("done pulses outstanding", done_q.size(), 0);
    done_q.delete();
    op_active = 1'b0;
    allowed   = '0;
  endtask

  task automatic do_abort();
    done_q.delete(done_q.size() - 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("scan_te after abort", scan_te, 0);
    check("scan_clk after abort", scan_clk, 0);
    check("scan_in after abort", scan_in, 0);
    check("busy after abort", bus.busy, 0);
    check("rdata after abort", bus.rdata, rdata_model);
    op_active = 1'b0;
    allowed   = '0;
    repeat (LAT) tick();
  endtask

  task automatic wait_rises(input int sel, input int n);
    int guard;
    guard = 0;
    while (rises[sel] < n && guard < 200) begin
      tick();
      guard++;
    end
    if (rises[sel] < n) check("wait for scan_clk rises", rises[sel], n);
  endtask

  task automatic pulse_reset(input logic with_req);
    rdata_model   = '0;
    rst           = 1'b1;
    bus.start     = with_req;
    bus.abort     = with_req;
    bus.chain_sel = '0;
    done_q.delete();
    err_q.delete();
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    op_active = 1'b0;
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset err", bus.err, 0);
    check("reset rdata", bus.rdata, 0);
    check("reset scan_te", scan_te, 0);
    check("reset scan_clk", scan_clk, 0);
    check("reset scan_in", scan_in, 0);
    allowed = '0;
    tick();
    check("busy after reset", bus.busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int sel, kind, n;
    logic [LEN-1:0] wd;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.chain_sel = '0;
    bus.wdata     = '0;
    chain[0]      = 8'hA5;
    chain[1]      = 8'h5A;
    rises         = '{default: 0};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checking = 1'b1;
    prev_clk = scan_clk;
    check("init busy", bus.busy, 0);
    check("init done", bus.done, 0);
    check("init err", bus.err, 0);
    check("init rdata", bus.rdata, 0);
    check("init scan pins", {scan_te, scan_clk, scan_in}, 0);

    issue(0, 8'h3C);
    finish_op();

    issue(2, 8'h11);
    tick();
    issue(1, 8'hFF);
    finish_op();

    chain[0] = 8'hA5;
    issue(0, 8'h3C);
    while (ncnt < op_start + 10) tick();
    issue(1, 8'h00);
    finish_op();

    issue(0, 8'h77);
    wait_rises(0, 3);
    do_abort();

    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("busy after idle abort", bus.busy, 0);

    issue(1, 8'h81);
    wait_rises(1, 4);
    tick();
    tick();
    pulse_reset(1'b1);
    issue(1, 8'h42);
    finish_op();

    for (int it = 0; it < 24; it++) begin
      sel  = int'($urandom_range(0, 2));
      kind = int'($urandom_range(0, 3));
      wd   = LEN'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      issue(sel, wd);
      if (sel < NCHAIN) begin
        if (kind == 1) begin
          n = int'($urandom_range(2, 30));
          while (ncnt < op_start + n) tick();
          issue(int'($urandom_range(0, 2)), LEN'($urandom));
          finish_op();
        end else if (kind == 2) begin
          n = int'($urandom_range(1, 36));
          while (ncnt < op_start + n) tick();
          do_abort();
        end else begin
          finish_op();
        end
      end else begin
        tick();
      end
    end

    repeat (3) tick();
    check("pending done at end", done_q.size(), 0);
    check("pending err at end", err_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
